stream_mux_rr: RTL
==================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshake and one registered output stage.
//  Generalises the 2:1 datapath mux: selection by external select (MODE_SEL) or fair round-robin arbitration (MODE_RR).
//  Sits between multiple producers (e.g. ALU result, load data, immediate path) and a single consumer stage.
// PARAMETERS
//  WIDTH  32  data width per channel
//  N      2   channel count, 2..16
//  MODE   0   0 = MODE_SEL (sel port chooses channel), 1 = MODE_RR (round-robin among valid channels)
//  SELW   $clog2(N)  select/channel-id width (derived localparam, min 1)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        synchronous active-low reset
//  in_data    in   N*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
//  in_valid   in   N        channel i offers a word
//  in_ready   out  N        channel i word accepted this cycle when in_valid[i] & in_ready[i]
//  sel        in   SELW     channel select, used only when MODE=0
//  out_data   out  WIDTH    registered selected word
//  out_chan   out  SELW     channel index that out_data came from
//  out_valid  out  1        out_data/out_chan hold a word
//  out_ready  in   1        consumer accepts word when out_valid & out_ready
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_chan=0, rr pointer=0; in_ready=0 while rst_n=0.
//  Reset mid-transfer: held output word is discarded; no input handshake completes that cycle.
//  load = !out_valid | out_ready (output register free or draining this cycle).
//  Grant (combinational, one-hot or zero):
//   MODE_SEL: grant[sel]=1 if sel<N, else no grant (all in_ready=0).
//   MODE_RR: first i with in_valid[i]=1 searching ptr, ptr+1, ... wrapping mod N; none valid -> no grant.
//  in_ready[i] = rst_n & load & grant[i]; at most one bit set. MODE_RR in_ready depends on in_valid;
//   producers must not make in_valid depend on in_ready.
//  Transfer on posedge when in_valid[g] & in_ready[g]: out_data<=in_data[g], out_chan<=g, out_valid<=1.
//  No transfer & out_ready & out_valid: out_valid<=0; out_data/out_chan keep last value.
//  Stall (out_valid & !out_ready): out_data, out_chan, out_valid held stable; in_ready all 0.
//  Latency 1 cycle input->output; throughput 1 word/cycle with out_ready held high.
//  RR pointer: on transfer from channel g, ptr <= (g==N-1) ? 0 : g+1; unchanged otherwise (incl. stalls).
//  Fairness: with all N channels continuously valid and out_ready=1, each channel granted once per N cycles.
//  sel may change every cycle; only its value in the transfer cycle matters.
//  in_valid of a non-granted channel is ignored; its word stays pending upstream.
// STRUCTURE
//  Shared package stream_pkg: localparam MODE_SEL=0, MODE_RR=1; clog2-min-1 helper function.
//  Sub-module rr_arbiter #(N): inputs clk, rst_n, req[N], advance; outputs grant[N] one-hot, grant_idx[SELW];
//   owns ptr register; advance = transfer strobe. Instantiated only under MODE_RR generate branch.
//  Top: grant select, load logic, output register; no other state.
// TESTING
//  1 MODE_SEL N=2: ch0=AAAA_AAAA, ch1=5555_5555 both valid, out_ready=1, sel=0 then 1
//    -> out_data AAAA_AAAA chan 0, next cycle 5555_5555 chan 1; in_ready=01 then 10.
//  2 MODE_SEL N=4 stall: ch2=FFFF_FFFF transferred, out_ready=0 for 3 cycles, ch2 updated to 0000_0000
//    -> out_data holds FFFF_FFFF, in_ready=0000; out_ready=1 -> 0000_0000 one cycle later.
//  3 MODE_RR N=4 all valid (data 0x1111_1111*(i+1)), out_ready=1 for 8 cycles
//    -> out_chan sequence 0,1,2,3,0,1,2,3; out_valid continuously 1.
//  4 MODE_RR N=4 only ch1,ch3 valid -> out_chan 1,3,1,3; then ch3 drops -> 1,1,1.
//  5 Reset mid-stall: out_valid=1 chan 2, rst_n=0 one cycle -> out_valid=0, out_data=0, out_chan=0, ptr=0;
//    after release with all valid -> first grant channel 0.
//  6 MODE_SEL N=3, sel=3 (out of range), all valid -> in_ready=000, out_valid falls to 0 after drain.

Source files
------------

// File: rtl/stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : stream_pkg                                                     |
// | Purpose : shared mode constants and width helper for the stream mux      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package stream_pkg;

   localparam int MODE_SEL = 0;
   localparam int MODE_RR  = 1;

   // Index width for n items, never below one bit so a 1-bit select still exists.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rr_arbiter                                                     |
// | Purpose : round-robin grant among N requesters, pointer moves on advance |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module rr_arbiter
   import stream_pkg::*;
#(
   parameter int N = 2,
   localparam int SELW = clog2_min1(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            advance,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] grant_idx
);

   localparam logic [SELW:0]   c_num  = (SELW+1)'(N);
   localparam logic [SELW-1:0] c_last = SELW'(N-1);

   logic [SELW-1:0] ptr_q;
   logic [SELW-1:0] ptr_d;
   logic [SELW:0]   cand;

   // Scan ptr, ptr+1, ... modulo N; first requester found wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr_q} + (SELW+1)'(k);
         if (cand >= c_num) cand = cand - c_num;
         if (grant == '0 && req[cand[SELW-1:0]]) begin
            grant[cand[SELW-1:0]] = 1'b1;
            grant_idx             = cand[SELW-1:0];
         end
      end
   end

   assign ptr_d = (grant_idx == c_last) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (advance) begin
         ptr_q <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : stream_mux_rr                                                  |
// | Purpose : N-channel valid/ready stream mux, select or round-robin mode,  |
// |           single registered output stage                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module stream_mux_rr
   import stream_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 2,
   parameter int MODE  = 0,
   localparam int SELW = clog2_min1(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SELW-1:0]    sel,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_chan,
   output logic               out_valid,
   input  logic               out_ready
);

   logic [N-1:0]     grant;
   logic [SELW-1:0]  grant_idx;
   logic             load;
   logic             xfer;
   logic [WIDTH-1:0] mux_data;

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_chan_q, out_chan_d;
   logic             out_valid_q, out_valid_d;

   assign load     = !out_valid_q || out_ready;
   assign in_ready = grant & {N{rst_n & load}};
   assign xfer     = |(in_valid & in_ready);

   generate
      if (MODE == MODE_SEL) begin : g_sel
         localparam logic [SELW:0] c_num = (SELW+1)'(N);
         // Out-of-range select grants nobody, so every producer sees ready low.
         always_comb begin
            grant     = '0;
            grant_idx = sel;
            if ({1'b0, sel} < c_num) grant[sel] = 1'b1;
         end
      end else begin : g_rr
         logic unused_sel;
         assign unused_sel = ^sel;

         rr_arbiter #(
            .N (N)
         ) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (in_valid),
            .advance   (xfer),
            .grant     (grant),
            .grant_idx (grant_idx)
         );
      end
   endgenerate

   // Grant is one-hot or zero, so an AND-OR mux is sufficient.
   always_comb begin
      mux_data = '0;
      for (int i = 0; i < N; i++) begin
         mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      if (xfer) begin
         out_data_d  = mux_data;
         out_chan_d  = grant_idx;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;

endmodule
`default_nettype wire
